// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// rst_seq_ctrl : reset sequencer with staggered channel release and watchdog
// Revision 1.0
// ============================================================================
`default_nettype none

module rst_seq_ctrl #(
  parameter int N_CH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 4,
  parameter int STAGGER     = 2,
  parameter int WDT_W       = 16,
  parameter int WDT_LIMIT   = 1000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_rst_req,
  input  logic             wdt_en,
  input  logic             wdt_kick,
  output logic [N_CH-1:0]  rst_out,
  output logic             rst_done,
  output logic [1:0]       rst_cause,
  output logic             wdt_fire,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int MAX_CYC = (HOLD_CYC > STAGGER) ? HOLD_CYC : STAGGER;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] STAG_LAST = TMR_W'(STAGGER - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(WDT_LIMIT - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;

  state_t           state,     state_nx;
  logic [TMR_W-1:0] tmr,       tmr_nx;
  logic [CH_W-1:0]  ch_idx,    ch_idx_nx;
  logic [WDT_W-1:0] wdt_cnt,   wdt_cnt_nx;
  logic [N_CH-1:0]  rst_out_nx;
  logic             rst_done_nx;
  logic [1:0]       rst_cause_nx;
  logic             wdt_fire_nx;
  logic [CNT_W-1:0] cycle_cnt_nx;
  logic             enter_hold;

  // Release synchroniser: assertion is asynchronous, deassertion is clocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      tmr       <= '0;
      ch_idx    <= '0;
      wdt_cnt   <= '0;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_POR;
      wdt_fire  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      ch_idx    <= ch_idx_nx;
      wdt_cnt   <= wdt_cnt_nx;
      rst_out   <= rst_out_nx;
      rst_done  <= rst_done_nx;
      rst_cause <= rst_cause_nx;
      wdt_fire  <= wdt_fire_nx;
      cycle_cnt <= cycle_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    tmr_nx       = tmr;
    ch_idx_nx    = ch_idx;
    wdt_cnt_nx   = wdt_cnt;
    rst_out_nx   = rst_out;
    rst_done_nx  = rst_done;
    rst_cause_nx = rst_cause;
    wdt_fire_nx  = 1'b0;
    cycle_cnt_nx = cycle_cnt;
    enter_hold   = 1'b0;

    case (state)
      ST_SYNC: begin
        if (sync_q[SYNC_STAGES-1]) begin
          enter_hold = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr == HOLD_LAST) begin
          rst_out_nx[0] = 1'b0;
          tmr_nx        = '0;
          if (N_CH == 1) begin
            state_nx    = ST_RUN;
            rst_done_nx = 1'b1;
          end else begin
            state_nx  = ST_RELEASE;
            ch_idx_nx = CH_W'(1);
          end
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (tmr == STAG_LAST) begin
          rst_out_nx[ch_idx] = 1'b0;
          tmr_nx             = '0;
          if (ch_idx == CH_LAST) begin
            state_nx    = ST_RUN;
            rst_done_nx = 1'b1;
          end else begin
            ch_idx_nx = ch_idx + 1'b1;
          end
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      ST_RUN: begin
        // A kick outranks expiry; expiry outranks a software request.
        if (wdt_kick) begin
          wdt_cnt_nx = '0;
        end else if (wdt_en) begin
          if (wdt_cnt == WDT_LAST) begin
            wdt_fire_nx  = 1'b1;
            rst_cause_nx = CAUSE_WDT;
            enter_hold   = 1'b1;
          end else begin
            wdt_cnt_nx = wdt_cnt + 1'b1;
          end
        end
        if (!enter_hold && soft_rst_req) begin
          rst_cause_nx = CAUSE_SOFT;
          enter_hold   = 1'b1;
        end
        if (!enter_hold && (cycle_cnt != '1)) begin
          cycle_cnt_nx = cycle_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_SYNC;
      end
    endcase

    if (enter_hold) begin
      state_nx     = ST_HOLD;
      rst_out_nx   = '1;
      rst_done_nx  = 1'b0;
      tmr_nx       = '0;
      ch_idx_nx    = '0;
      wdt_cnt_nx   = '0;
      cycle_cnt_nx = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// tb_rst_seq_ctrl : randomised, model-checked bench for rst_seq_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

  localparam int N_CH        = 3;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYC    = 4;
  localparam int STAGGER     = 2;
  localparam int WDT_W       = 16;
  localparam int WDT_LIMIT   = 8;
  localparam int CNT_W       = 6;
  localparam int T_DONE      = HOLD_CYC + (N_CH - 1) * STAGGER;
  localparam int CYC_MAX     = (1 << CNT_W) - 1;
  localparam int VW          = N_CH + 1 + 2 + 1 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             soft_rst_req = 1'b0;
  logic             wdt_en = 1'b0;
  logic             wdt_kick = 1'b0;
  logic [N_CH-1:0]  rst_out;
  logic             rst_done;
  logic [1:0]       rst_cause;
  logic             wdt_fire;
  logic [CNT_W-1:0] cycle_cnt;
  logic [VW-1:0]    got_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .HOLD_CYC(HOLD_CYC),
    .STAGGER(STAGGER), .WDT_W(WDT_W), .WDT_LIMIT(WDT_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
    .wdt_en(wdt_en), .wdt_kick(wdt_kick), .rst_out(rst_out),
    .rst_done(rst_done), .rst_cause(rst_cause), .wdt_fire(wdt_fire),
    .cycle_cnt(cycle_cnt)
  );

  assign got_vec = {rst_out, rst_done, rst_cause, wdt_fire, cycle_cnt};

  // Reference model: time elapsed since the last HOLD entry decides everything.
  bit         m_in_sync;
  int         m_sync_edges;
  int         m_since;
  int         m_wdt;
  int         m_cyc;
  logic [1:0] m_cause;
  bit         m_fire;

  function automatic void model_reset();
    m_in_sync = 1; m_sync_edges = 0; m_since = 0;
    m_wdt = 0; m_cyc = 0; m_cause = 2'b00; m_fire = 0;
  endfunction

  function automatic void model_enter_hold();
    m_in_sync = 0; m_since = 0; m_wdt = 0; m_cyc = 0;
  endfunction

  function automatic bit model_done();
    return !m_in_sync && (m_since >= T_DONE);
  endfunction

  function automatic void model_step();
    m_fire = 0;
    if (!reset) begin
      model_reset();
    end else if (m_in_sync) begin
      m_sync_edges++;
      if (m_sync_edges == SYNC_STAGES + 1) model_enter_hold();
    end else if (model_done()) begin
      if (wdt_en && !wdt_kick && (m_wdt + 1 == WDT_LIMIT)) begin
        m_fire = 1; m_cause = 2'b10; model_enter_hold();
      end else if (soft_rst_req) begin
        m_cause = 2'b01; model_enter_hold();
      end else begin
        if (wdt_kick) m_wdt = 0;
        else if (wdt_en) m_wdt++;
        if (m_cyc < CYC_MAX) m_cyc++;
      end
    end else begin
      m_since++;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++)
      r[k] = m_in_sync || (m_since < HOLD_CYC + k * STAGGER);
    return {r, model_done(), m_cause, m_fire, CNT_W'(m_cyc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic power_on_start();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got_vec !== {3'b111, 1'b0, 2'b00, 1'b0, 6'd0}) begin
      errors++; $display("FAIL reset_async: got %h required %h", got_vec, {3'b111, 1'b0, 2'b00, 1'b0, 6'd0});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (got_vec !== {3'b111, 1'b0, 2'b00, 1'b0, 6'd0}) begin
        errors++; $display("FAIL reset_hold cyc %0d: got %h required %h", i, got_vec, {3'b111, 1'b0, 2'b00, 1'b0, 6'd0});
      end
    end
  endtask

  task automatic test_power_on();
    logic [N_CH-1:0] want;
    power_on_start();
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL power_on edge %0d: got %h required %h", e, got_vec, exp_vec());
      end
      want = (e < 7) ? 3'b111 : (e < 9) ? 3'b110 : (e < 11) ? 3'b100 : 3'b000;
      checks++;
      if (rst_out !== want || rst_done !== (e >= 11) || rst_cause !== 2'b00) begin
        errors++; $display("FAIL power_on_edge_table edge %0d: got %b/%b/%b required %b/%b/00", e, rst_out, rst_done, rst_cause, want, (e >= 11));
      end
    end
  endtask

  task automatic test_async_mid_release();
    power_on_start();
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL mid_release pre edge %0d: got %h required %h", e, got_vec, exp_vec());
      end
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rst_out !== 3'b111 || rst_done !== 1'b0) begin
      errors++; $display("FAIL mid_release_async: got %b/%b required 111/0", rst_out, rst_done);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL mid_release post edge %0d: got %h required %h", e, got_vec, exp_vec());
      end
    end
    checks++;
    if (rst_out !== 3'b000 || rst_done !== 1'b1) begin
      errors++; $display("FAIL mid_release_redone: got %b/%b required 000/1", rst_out, rst_done);
    end
  endtask

  task automatic test_soft();
    int budget = 50;
    while (m_cyc != 10 && budget > 0) begin
      tick();
      budget--;
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL soft_run: got %h required %h", got_vec, exp_vec());
      end
    end
    checks++;
    if (cycle_cnt !== 6'd10) begin
      errors++; $display("FAIL soft_precount: got %0d required 10", cycle_cnt);
    end
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    checks++;
    if (rst_out !== 3'b111 || rst_done !== 1'b0 || cycle_cnt !== 6'd0 || rst_cause !== 2'b01) begin
      errors++; $display("FAIL soft_edge: got %b/%b/%0d/%b required 111/0/0/01", rst_out, rst_done, cycle_cnt, rst_cause);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec() || rst_out[0] !== (j < 4) || rst_out[2] !== (j < 8)) begin
        errors++; $display("FAIL soft_release n+%0d: got %h required %h", j, got_vec, exp_vec());
      end
    end
  endtask

  task automatic drain_to_run(input string name);
    int budget = 20;
    while (!model_done() && budget > 0) begin
      tick();
      budget--;
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL %s drain: got %h required %h", name, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_watchdog();
    wdt_en = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if (got_vec !== exp_vec() || wdt_fire !== (j == 8)) begin
        errors++; $display("FAIL wdt_run edge %0d: got %h required %h", j, got_vec, exp_vec());
      end
    end
    checks++;
    if (rst_out !== 3'b111 || rst_cause !== 2'b10 || rst_done !== 1'b0) begin
      errors++; $display("FAIL wdt_fire_state: got %b/%b/%b required 111/10/0", rst_out, rst_cause, rst_done);
    end
    wdt_en = 1'b0;
    tick();
    checks++;
    if (wdt_fire !== 1'b0) begin
      errors++; $display("FAIL wdt_pulse_width: got %b required 0", wdt_fire);
    end
    drain_to_run("wdt");
  endtask

  task automatic test_kicks();
    wdt_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wdt_kick = (i % 5 == 4);
      tick();
      checks++;
      if (got_vec !== exp_vec() || wdt_fire !== 1'b0) begin
        errors++; $display("FAIL kick_periodic cyc %0d: got %h required %h", i, got_vec, exp_vec());
      end
    end
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      wdt_kick = (j == 8);
      tick();
      checks++;
      if (got_vec !== exp_vec() || wdt_fire !== 1'b0) begin
        errors++; $display("FAIL kick_on_8th edge %0d: got %h required %h", j, got_vec, exp_vec());
      end
    end
    wdt_kick = 1'b0;
    wdt_en = 1'b0;
  endtask

  task automatic test_soft_and_expiry();
    wdt_en = 1'b1;
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      soft_rst_req = (j == 8);
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL soft_wdt edge %0d: got %h required %h", j, got_vec, exp_vec());
      end
    end
    soft_rst_req = 1'b0;
    wdt_en = 1'b0;
    checks++;
    if (wdt_fire !== 1'b1 || rst_cause !== 2'b10 || rst_out !== 3'b111) begin
      errors++; $display("FAIL soft_wdt_priority: got %b/%b/%b required 1/10/111", wdt_fire, rst_cause, rst_out);
    end
    drain_to_run("soft_wdt");
  endtask

  task automatic test_soft_in_hold();
    power_on_start();
    for (int e = 1; e <= 11; e++) begin
      soft_rst_req = (e == 5 || e == 8);
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL soft_in_hold edge %0d: got %h required %h", e, got_vec, exp_vec());
      end
    end
    soft_rst_req = 1'b0;
    checks++;
    if (rst_out !== 3'b000 || rst_done !== 1'b1 || rst_cause !== 2'b00) begin
      errors++; $display("FAIL soft_in_hold_final: got %b/%b/%b required 000/1/00", rst_out, rst_done, rst_cause);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if (cycle_cnt !== 6'h3F || got_vec !== exp_vec()) begin
      errors++; $display("FAIL cycle_saturate: got %0d required 63", cycle_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(149, 0) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got_vec !== exp_vec()) begin
          errors++; $display("FAIL random_async cyc %0d: got %h required %h", i, got_vec, exp_vec());
        end
      end
      soft_rst_req = ($urandom_range(29, 0) == 0);
      wdt_en       = ($urandom_range(3, 0) != 0);
      wdt_kick     = ($urandom_range(6, 0) == 0);
      tick();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h required %h", i, got_vec, exp_vec());
      end
    end
    soft_rst_req = 1'b0;
    wdt_en = 1'b0;
    wdt_kick = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_on();
    test_async_mid_release();
    test_soft();
    test_watchdog();
    test_kicks();
    test_soft_and_expiry();
    test_soft_in_hold();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer and run-time supervisor for the pipelined MIPS core and its peripherals. It takes the board-level asynchronous active-low reset, synchronises its release, and holds N_CH downstream active-high synchronous resets for a programmable time. It then releases those resets in a staggered order (CPU core, bridge, devices). It also supports software-requested reset, a watchdog that re-resets a hung core, a cause register, and a run-cycle counter for benches and debug.

Parameters:
N_CH, 3, number of downstream reset channels (>=1); channel 0 is released first.
SYNC_STAGES, 2, synchroniser depth for reset release (>=2).
HOLD_CYC, 4, cycles all channels stay asserted after HOLD entry (>=1).
STAGGER, 2, cycles between successive channel releases (>=1).
WDT_W, 16, watchdog counter width.
WDT_LIMIT, 1000, unkicked enabled RUN cycles before the watchdog fires (1..2^WDT_W-1).
CNT_W, 32, run-cycle counter width.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
soft_rst_req  in  1  software reset request, sampled on the clk rising edge.
wdt_en  in  1  watchdog enable.
wdt_kick  in  1  watchdog service pulse.
rst_out  out  N_CH  per-channel active-high synchronous reset.
rst_done  out  1  high when all channels are released.
rst_cause  out  2  cause of the last reset: 00 power-on, 01 soft, 10 watchdog.
wdt_fire  out  1  one-cycle pulse when the watchdog expires.
cycle_cnt  out  CNT_W  rising edges since rst_done rose; saturates at all-ones.

Behaviour:
- reset low (async, any state): rst_out = all ones, rst_done = 0, rst_cause = 00, wdt_fire = 0, cycle_cnt = 0. Internal state: SYNC, synchroniser cleared, all counters cleared.
- Release path: the synchroniser shifts in 1 after reset goes high. Its output is high after SYNC_STAGES edges. On the next edge the FSM enters HOLD.
- FSM states: SYNC, HOLD, RELEASE, RUN.
  - SYNC->HOLD: when the synchroniser output is high.
  - HOLD: lasts HOLD_CYC cycles. Channel 0 deasserts on edge E+HOLD_CYC, where E is the HOLD entry edge. The FSM enters RELEASE on that same edge.
  - RELEASE: channel k deasserts on edge E+HOLD_CYC+k*STAGGER.
  - RELEASE->RUN: on the edge that releases channel N_CH-1, rst_done goes to 1 on the same edge. With N_CH=1, RUN is entered directly from HOLD.
- Power-on timing: channel k falls on edge SYNC_STAGES+1+HOLD_CYC+k*STAGGER, counting edges after reset rises.
- Release order: a channel that has been released is never re-asserted except by re-entry to HOLD. When re-entering HOLD, all channels assert on the entry edge.
- Soft reset: soft_rst_req=1 in RUN at edge n causes the following on edge n:
  - rst_out = all ones, rst_done = 0, cycle_cnt = 0;
  - rst_cause = 01, and the FSM enters HOLD.
  - soft_rst_req is ignored in SYNC, HOLD and RELEASE.
- Watchdog (counts only in RUN):
  - wdt_cnt increments each RUN edge with wdt_en=1 and wdt_kick=0.
  - wdt_kick=1 clears wdt_cnt to 0.
  - wdt_en=0 holds wdt_cnt.
  - wdt_cnt is cleared on every HOLD entry.
  - Expiry: the edge on which wdt_cnt would reach WDT_LIMIT makes wdt_fire=1 for exactly one cycle, rst_cause = 10, and the FSM enters HOLD. This happens after WDT_LIMIT unkicked enabled cycles.
- Simultaneous events:
  - Kick and expiry on the same edge: the kick wins, so there is no fire.
  - Soft request and expiry on the same edge: the FSM enters HOLD, wdt_fire pulses, and rst_cause = 10 (watchdog has priority).
  - reset low at any time overrides everything, including mid-RELEASE.
- cycle_cnt increments only in RUN and stops at 2^CNT_W-1.
- rst_cause holds its value until the next reset event.

Test Plan:
- Power-on with defaults: reset low 2 cycles, then high between edges. Required response:
  - rst_out[0] falls on edge 7, rst_out[1] on edge 9, rst_out[2] on edge 11;
  - rst_done rises on edge 11; rst_cause = 00.
- Mid-RELEASE async reset: pull reset low just after edge 8. Required response:
  - rst_out returns to 3'b111 immediately (without waiting for a clock edge);
  - after release, the full 7/9/11 sequence repeats.
- Soft reset: 10 cycles into RUN (cycle_cnt=10), pulse soft_rst_req for 1 cycle at edge n. Required response:
  - rst_out = 111, rst_done = 0, cycle_cnt = 0 at edge n;
  - rst_out[0] falls at n+4, rst_out[2] falls at n+8; rst_cause = 01.
- Watchdog expiry with WDT_LIMIT=8: wdt_en=1, no kick. Required response:
  - wdt_fire pulses high for 1 cycle on the 8th RUN edge;
  - rst_out = 111, rst_cause = 10, then the normal release sequence follows.
- Kicks: kick every 5 cycles for 100 cycles -> wdt_fire stays 0. Kick on exactly the 8th edge -> no fire.
- Soft request and watchdog expiry on the same edge -> wdt_fire=1 and rst_cause=10. Soft request during HOLD -> ignored; release timing is unchanged.
